// File: rtl/breakout_flow_ctrl_pkg.sv
// Shared Breakout definitions: state encodings, life limits and score saturation.
// The HUD renderer imports the same package to decode state_code.
package breakout_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_PAUSE = 3'd3,
      ST_LOST  = 3'd4,
      ST_CLEAR = 3'd5,
      ST_OVER  = 3'd6
   } state_e;

   localparam int unsigned LIVES_MIN     = 1;
   localparam int unsigned LIVES_MAX     = 3;
   localparam int unsigned SCORE_W       = 12;
   localparam int unsigned CORE_SCORE_W  = 10;
   localparam int unsigned BRICKS_W      = 48;
   localparam int unsigned LEVEL_MAX     = 15;
   localparam int unsigned DLY_W         = 12;
   localparam int unsigned SERVE_STEP_MS = 1000;
   localparam int unsigned SERVE_MS      = 3000;

   // Carry out of the score adder means the 12-bit total overflowed.
   function automatic logic [SCORE_W-1:0] sat12(input logic [SCORE_W:0] s);
      return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
   endfunction

endpackage

// File: rtl/breakout_flow_ctrl_if.sv
// Game-core link: run/reinit controls out, ball/brick/score status back.
interface breakout_flow_ctrl_if;

   logic                                    game_run;
   logic                                    new_game;
   logic                                    ball_lost;
   logic [breakout_pkg::BRICKS_W-1:0]       bricks_alive;
   logic [breakout_pkg::CORE_SCORE_W-1:0]   score;

   modport master (
      output game_run, new_game,
      input  ball_lost, bricks_alive, score
   );

   modport slave (
      input  game_run, new_game,
      output ball_lost, bricks_alive, score
   );

endinterface

// File: rtl/breakout_flow_ctrl_ms_tick_gen.sv
// Free-running millisecond prescaler: one-cycle ms_tick every CLK_FREQ_HZ/1000 clocks.
module ms_tick_gen #(
   parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
   input  logic clk,
   input  logic reset_n,
   output logic ms_tick
);

   localparam int unsigned DIV = (CLK_FREQ_HZ / 1000 < 1) ? 1 : CLK_FREQ_HZ / 1000;
   localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;
   logic          wrap;

   always_comb wrap = (cnt == CW'(DIV - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt     <= '0;
         ms_tick <= 1'b0;
      end else begin
         cnt     <= wrap ? '0 : cnt + 1'b1;
         ms_tick <= wrap;
      end
   end

endmodule

// File: rtl/breakout_flow_ctrl.sv
// Breakout game flow FSM: serve countdown, play/pause, life loss, level clear,
// game over, banked score and high score.
module breakout_flow_ctrl
   import breakout_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 50_000_000,
   parameter int unsigned LIVES_INIT  = 3,
   parameter int unsigned LOST_MS     = 1000
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                tap,
   input  logic                pause_tap,
   breakout_flow_ctrl_if.master core,
   output logic [1:0]          lives,
   output logic [3:0]          level,
   output logic [1:0]          countdown,
   output logic [SCORE_W-1:0]  total_score,
   output logic [SCORE_W-1:0]  high_score,
   output logic [2:0]          state_code
);

   localparam int unsigned LIVES_CLAMP =
      (LIVES_INIT < LIVES_MIN) ? LIVES_MIN :
      (LIVES_INIT > LIVES_MAX) ? LIVES_MAX : LIVES_INIT;

   state_e             state;
   logic [DLY_W-1:0]   dly;
   logic [DLY_W-1:0]   dly_inc;
   logic [SCORE_W-1:0] banked;
   logic [SCORE_W-1:0] sum_sat;
   logic               game_run_q;
   logic               new_game_q;
   logic               ms_tick;
   logic               hold_done;
   logic               serve_done;
   logic               pause_req;
   logic               resume_req;
   logic               run_phase;

   ms_tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_ms_tick_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .ms_tick (ms_tick)
   );

   function automatic logic [1:0] serve_count(input logic [DLY_W-1:0] d);
      if (d < DLY_W'(SERVE_STEP_MS))          return 2'd3;
      else if (d < DLY_W'(2 * SERVE_STEP_MS)) return 2'd2;
      else                                    return 2'd1;
   endfunction

   // Shared adder feeds both the banking update and the PLAY/PAUSE total.
   always_comb begin
      dly_inc    = dly + DLY_W'(ms_tick);
      hold_done  = ms_tick && (dly == DLY_W'(LOST_MS - 1));
      serve_done = ms_tick && (dly == DLY_W'(SERVE_MS - 1));
      sum_sat    = sat12({1'b0, banked} + (SCORE_W + 1)'(core.score));
      pause_req  = pause_tap & ~tap;
      resume_req = pause_tap | tap;
      run_phase  = (state == ST_PLAY) || (state == ST_PAUSE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         dly         <= '0;
         game_run_q  <= 1'b0;
         new_game_q  <= 1'b0;
         lives       <= '0;
         level       <= '0;
         countdown   <= '0;
         banked      <= '0;
         total_score <= '0;
         high_score  <= '0;
      end else begin
         dly         <= dly_inc;
         new_game_q  <= 1'b0;
         total_score <= run_phase ? sum_sat : banked;
         case (state)
            ST_IDLE: if (tap) begin
               state      <= ST_SERVE;
               dly        <= '0;
               new_game_q <= 1'b1;
               countdown  <= 2'd3;
               lives      <= 2'(LIVES_CLAMP);
               level      <= 4'd1;
               banked     <= '0;
            end
            ST_SERVE: if (serve_done) begin
               state      <= ST_PLAY;
               dly        <= '0;
               countdown  <= '0;
               game_run_q <= 1'b1;
            end else begin
               countdown  <= serve_count(dly_inc);
            end
            ST_PLAY: if (core.bricks_alive == '0) begin
               state      <= ST_CLEAR;
               dly        <= '0;
               game_run_q <= 1'b0;
               banked     <= sum_sat;
               level      <= (level == 4'(LEVEL_MAX)) ? level : level + 4'd1;
            end else if (core.ball_lost) begin
               state      <= ST_LOST;
               dly        <= '0;
               game_run_q <= 1'b0;
               banked     <= sum_sat;
               lives      <= (lives != '0) ? lives - 2'd1 : '0;
            end else if (pause_req) begin
               state      <= ST_PAUSE;
               dly        <= '0;
               game_run_q <= 1'b0;
            end
            ST_PAUSE: if (resume_req) begin
               state      <= ST_PLAY;
               dly        <= '0;
               game_run_q <= 1'b1;
            end
            ST_LOST: if (hold_done) begin
               dly <= '0;
               if (lives == '0) begin
                  state <= ST_OVER;
                  if (banked > high_score) high_score <= banked;
               end else begin
                  state      <= ST_SERVE;
                  new_game_q <= 1'b1;
                  countdown  <= 2'd3;
               end
            end
            ST_CLEAR: if (hold_done) begin
               state      <= ST_SERVE;
               dly        <= '0;
               new_game_q <= 1'b1;
               countdown  <= 2'd3;
            end
            ST_OVER: if (tap) begin
               state <= ST_IDLE;
               dly   <= '0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign core.game_run = game_run_q;
   assign core.new_game = new_game_q;
   assign state_code    = state;

endmodule

// File: tb/tb_breakout_flow_ctrl.sv
// Directed bench for breakout_flow_ctrl at 1 ms per clock with a 4 ms hold.
`timescale 1ns/1ps
module tb_breakout_flow_ctrl;
   import breakout_pkg::*;

   localparam int DC = -1;
   localparam logic [47:0] SOME_BRICKS = 48'h0000_F0F0_0001;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        tap = 1'b0;
   logic        pause_tap = 1'b0;
   logic [1:0]  lives;
   logic [3:0]  level;
   logic [1:0]  countdown;
   logic [11:0] total_score;
   logic [11:0] high_score;
   logic [2:0]  state_code;
   logic        pre_tick;

   int n_chk = 0;
   int n_fail = 0;

   breakout_flow_ctrl_if bus();

   breakout_flow_ctrl #(.CLK_FREQ_HZ(1000), .LIVES_INIT(3), .LOST_MS(4)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .tap         (tap),
      .pause_tap   (pause_tap),
      .core        (bus),
      .lives       (lives),
      .level       (level),
      .countdown   (countdown),
      .total_score (total_score),
      .high_score  (high_score),
      .state_code  (state_code)
   );

   ms_tick_gen #(.CLK_FREQ_HZ(3000)) u_pre (
      .clk     (clk),
      .reset_n (reset_n),
      .ms_tick (pre_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      string name;
      bit    wait_play;
      bit    t, p, lost, bz;
      int    score;
      int    st, run, ng, lv, lvl, cd, tot, hi;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(string name, bit wp, bit t, bit p, bit lost, bit bz, int score,
                               int st, int run, int ng, int lv, int lvl, int cd, int tot, int hi);
      vec_t v;
      v.name = name; v.wait_play = wp; v.t = t; v.p = p; v.lost = lost; v.bz = bz;
      v.score = score; v.st = st; v.run = run; v.ng = ng; v.lv = lv; v.lvl = lvl;
      v.cd = cd; v.tot = tot; v.hi = hi;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      if (exp < 0) return;
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic wait_state(input int code, input int budget, input string nm);
      int n = 0;
      while (int'(state_code) != code && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      chk(nm, int'(state_code), code);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.ball_lost    = 1'b0;
      bus.bricks_alive = SOME_BRICKS;
      bus.score        = '0;

      //           name          wp t p l b score  st run ng lv lvl  cd   tot   hi
      add("lost1",        0, 0,0,1,0,  40,   4, 0, 0, 2, 1,  0,   40,   0);
      add("lost_hold1",   0, 0,0,1,0,  40,   4, 0, 0, 2, 1,  0,   40,   0);
      add("lost_hold2",   0, 0,0,1,0,  40,   4, 0, 0,DC,DC, DC,   40,  DC);
      add("lost_hold3",   0, 0,0,1,0,  40,   4, 0, 0,DC,DC, DC,   40,  DC);
      add("lost_serve",   0, 0,0,1,0,  40,   1, 0, 1, 2, 1,  3,   40,   0);
      add("serve_ng_off", 0, 0,0,0,0,   0,   1, 0, 0, 2, 1,  3,   40,  DC);
      add("clr_and_lost", 1, 0,0,1,1,  30,   5, 0, 0, 2, 2,  0,   70,   0);
      add("clr_hold1",    0, 0,0,1,1,  30,   5, 0, 0,DC, 2, DC,   70,  DC);
      add("clr_hold2",    0, 0,0,1,1,  30,   5,DC,DC,DC,DC, DC,   70,  DC);
      add("clr_hold3",    0, 0,0,1,1,  30,   5,DC,DC,DC,DC, DC,   70,  DC);
      add("clr_serve",    0, 0,0,0,0,   0,   1, 0, 1, 2, 2,  3,   70,  DC);
      add("serve2",       0, 0,0,0,0,   0,   1, 0, 0,DC,DC,  3,   70,  DC);
      add("pause",        1, 0,1,0,0,   5,   3, 0, 0, 2, 2,  0,   75,  DC);
      add("pause_ign",    0, 0,0,1,1,   5,   3, 0, 0, 2, 2, DC,   75,  DC);
      add("resume",       0, 1,0,0,0,   5,   2, 1, 0, 2, 2, DC,   75,  DC);
      add("both_taps",    0, 1,1,0,0,   5,   2, 1, 0,DC,DC, DC,   75,  DC);
      add("lost2",        0, 0,0,1,0,  30,   4, 0, 0, 1, 2, DC,  100,  DC);
      add("lost2_h1",     0, 0,0,1,0,  30,   4,DC,DC,DC,DC, DC,  100,  DC);
      add("lost2_h2",     0, 0,0,1,0,  30,   4,DC,DC,DC,DC, DC,   DC,  DC);
      add("lost2_h3",     0, 0,0,1,0,  30,   4,DC,DC,DC,DC, DC,   DC,  DC);
      add("lost2_serve",  0, 0,0,1,0,  30,   1, 0, 1, 1, 2,  3,  100,  DC);
      add("serve3",       0, 0,0,0,0,   0,   1, 0, 0,DC,DC, DC,  100,  DC);
      add("lost3",        1, 0,0,1,0,  20,   4, 0, 0, 0, 2, DC,  120,   0);
      add("lost3_h1",     0, 0,0,1,0,  20,   4,DC,DC, 0,DC, DC,  120,  DC);
      add("lost3_h2",     0, 0,0,1,0,  20,   4,DC,DC,DC,DC, DC,   DC,  DC);
      add("lost3_h3",     0, 0,0,1,0,  20,   4,DC,DC,DC,DC, DC,   DC,   0);
      add("over",         0, 0,0,1,0,  20,   6, 0, 0, 0,DC,  0,  120, 120);
      add("over_hold",    0, 0,0,0,0,   0,   6, 0, 0,DC,DC, DC,  120, 120);
      add("to_idle",      0, 1,0,0,0,   0,   0, 0, 0, 0,DC,  0,  120, 120);
      add("game2",        0, 1,0,0,0,   0,   1, 0, 1, 3, 1,  3,   DC, 120);
      add("game2_serve",  0, 0,0,0,0,   0,   1, 0, 0, 3, 1,  3,    0, 120);
      add("clr1",         1, 0,0,0,1,1023,   5, 0, 0, 3, 2, DC, 1023, 120);
      add("clr1_rel",     0, 0,0,0,0,   0,   5,DC,DC,DC,DC, DC, 1023,  DC);
      add("clr2",         1, 0,0,0,1,1023,   5, 0, 0, 3, 3, DC, 2046,  DC);
      add("clr2_rel",     0, 0,0,0,0,   0,   5,DC,DC,DC,DC, DC, 2046,  DC);
      add("clr3",         1, 0,0,0,1,1023,   5, 0, 0, 3, 4, DC, 3069,  DC);
      add("clr3_rel",     0, 0,0,0,0,   0,   5,DC,DC,DC,DC, DC, 3069,  DC);
      add("clr4",         1, 0,0,0,1,1021,   5, 0, 0, 3, 5, DC, 4090,  DC);
      add("clr4_rel",     0, 0,0,0,0,   0,   5,DC,DC,DC,DC, DC, 4090,  DC);
      add("lost_sat",     1, 0,0,1,0,  10,   4, 0, 0, 2, 5, DC, 4095, 120);
      add("lost_sat_h1",  0, 0,0,1,0,  10,   4,DC,DC,DC,DC, DC, 4095,  DC);

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst.state", int'(state_code), 0);
      chk("rst.game_run", int'(bus.game_run), 0);
      chk("rst.new_game", int'(bus.new_game), 0);
      chk("rst.lives", int'(lives), 0);
      chk("rst.level", int'(level), 0);
      chk("rst.countdown", int'(countdown), 0);
      chk("rst.total", int'(total_score), 0);
      chk("rst.high", int'(high_score), 0);
      @(negedge clk) reset_n = 1'b1;
      repeat (3) @(posedge clk);

      // First serve: tap, new_game pulse, 3/2/1 countdown, PLAY at 3000 ms
      @(negedge clk) tap = 1'b1;
      @(posedge clk); #1; tap = 1'b0;
      chk("serve.state", int'(state_code), 1);
      chk("serve.new_game", int'(bus.new_game), 1);
      chk("serve.lives", int'(lives), 3);
      chk("serve.level", int'(level), 1);
      chk("serve.cd0", int'(countdown), 3);
      for (int k = 1; k <= 3000; k++) begin
         @(posedge clk); #1;
         if (k == 1) chk("serve.ng_drop", int'(bus.new_game), 0);
         if (k == 999 || k == 1000 || k == 1999 || k == 2000 || k == 2999) begin
            chk($sformatf("serve.cd%0d", k), int'(countdown), 3 - k / 1000);
            chk($sformatf("serve.st%0d", k), int'(state_code), 1);
            chk($sformatf("serve.run%0d", k), int'(bus.game_run), 0);
         end
         if (k == 3000) begin
            chk("serve.play", int'(state_code), 2);
            chk("serve.run", int'(bus.game_run), 1);
            chk("serve.cd_off", int'(countdown), 0);
         end
      end

      foreach (tbl[i]) begin
         if (tbl[i].wait_play) wait_state(2, 3100, {tbl[i].name, ".wait"});
         @(negedge clk);
         tap              = tbl[i].t;
         pause_tap        = tbl[i].p;
         bus.ball_lost    = tbl[i].lost;
         bus.bricks_alive = tbl[i].bz ? '0 : SOME_BRICKS;
         bus.score        = 10'(tbl[i].score);
         @(posedge clk); #1;
         tap = 1'b0;
         pause_tap = 1'b0;
         chk({tbl[i].name, ".state"}, int'(state_code), tbl[i].st);
         chk({tbl[i].name, ".run"}, int'(bus.game_run), tbl[i].run);
         chk({tbl[i].name, ".ng"}, int'(bus.new_game), tbl[i].ng);
         chk({tbl[i].name, ".lives"}, int'(lives), tbl[i].lv);
         chk({tbl[i].name, ".level"}, int'(level), tbl[i].lvl);
         chk({tbl[i].name, ".cd"}, int'(countdown), tbl[i].cd);
         chk({tbl[i].name, ".total"}, int'(total_score), tbl[i].tot);
         chk({tbl[i].name, ".high"}, int'(high_score), tbl[i].hi);
      end

      // Asynchronous reset in SERVE clears everything including high_score
      wait_state(1, 100, "mid_rst.wait_serve");
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst.state", int'(state_code), 0);
      chk("mid_rst.game_run", int'(bus.game_run), 0);
      chk("mid_rst.new_game", int'(bus.new_game), 0);
      chk("mid_rst.lives", int'(lives), 0);
      chk("mid_rst.level", int'(level), 0);
      chk("mid_rst.countdown", int'(countdown), 0);
      chk("mid_rst.total", int'(total_score), 0);
      chk("mid_rst.high", int'(high_score), 0);
      bus.ball_lost = 1'b0;
      bus.score     = '0;
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst.state", int'(state_code), 0);
      @(negedge clk) tap = 1'b1;
      @(posedge clk); #1; tap = 1'b0;
      chk("post_rst.serve", int'(state_code), 1);
      chk("post_rst.lives", int'(lives), 3);
      chk("post_rst.high", int'(high_score), 0);

      // Prescaler at divide-by-3
      begin
         int ticks = 0;
         int adj = 0;
         logic prev = 1'b0;
         for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (pre_tick) ticks++;
            if (pre_tick && prev) adj++;
            prev = pre_tick;
         end
         chk("prescale.ticks", ticks, 10);
         chk("prescale.adjacent", adj, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/breakout_flow_ctrl.md
BREAKOUT_FLOW_CTRL -- requirements
Module: breakout_flow_ctrl

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 50_000_000: clk frequency; the ms prescaler divides by CLK_FREQ_HZ/1000.
REQ-002 Parameter LIVES_INIT, default 3: lives granted at game start (1..3).
REQ-003 Parameter LOST_MS, default 1000: hold time in the LOST and CLEAR states.
REQ-004 clk  in  1  system clock.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 tap  in  1  1-cycle pulse, debounced touch tap.
REQ-007 pause_tap  in  1  1-cycle pulse, pause-button touch.
REQ-008 ball_lost  in  1  from the game core; latched high until new_game.
REQ-009 bricks_alive  in  48  brick-alive mask from the game core.
REQ-010 score  in  10  live score from the game core.
REQ-011 game_run  out  1  core run enable.
REQ-012 new_game  out  1  1-cycle core reinit pulse.
REQ-013 lives  out  2  remaining lives.
REQ-014 level  out  4  current level, 1..15.
REQ-015 countdown  out  2  serve countdown 3/2/1; 0 outside SERVE.
REQ-016 total_score  out  12  banked score plus live score.
REQ-017 high_score  out  12  best total since reset.
REQ-018 state_code  out  3  state for HUD: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, LOST=4, CLEAR=5, OVER=6.

Function
REQ-019 Registered FSM with the 7 states of REQ-018; all outputs registered.
REQ-020 ms_tick: 1-cycle pulse every CLK_FREQ_HZ/1000 clks, free-running; the delay counter counts ms_ticks, 12 bits, cleared on every state entry.
REQ-021 IDLE: tap -> SERVE; lives<=LIVES_INIT, level<=1, banked<=0.
REQ-022 new_game=1 for exactly the first cycle of every SERVE entry, 0 otherwise.
REQ-023 SERVE: countdown=3 for 0..999 ms, 2 for 1000..1999 ms, 1 for 2000..2999 ms; at 3000 ms -> PLAY; taps ignored.
REQ-024 game_run=1 only in PLAY.
REQ-025 PLAY priority, highest first: bricks_alive==0 -> CLEAR; ball_lost -> LOST; pause_tap -> PAUSE.
REQ-026 PAUSE: pause_tap or tap -> PLAY; ball_lost/bricks ignored.
REQ-027 On LOST entry: banked<=sat12(banked+score); lives<=lives-1.
REQ-028 LOST after LOST_MS: lives==0 -> OVER, else -> SERVE.
REQ-029 On CLEAR entry: banked<=sat12(banked+score); level<=min(level+1,15).
REQ-030 CLEAR after LOST_MS -> SERVE.
REQ-031 OVER entry: if banked>high_score, high_score<=banked; OVER: tap -> IDLE.
REQ-032 total_score=sat12(banked+score) in PLAY/PAUSE, =banked in all other states (no double count); registered, 1-clk latency.
REQ-033 sat12: clamp to 4095; lives never underflow; level never wraps.
REQ-034 tap and pause_tap in the same cycle: tap semantics apply.

Reset
REQ-035 reset_n low: state=IDLE, game_run=0, new_game=0, lives=0, level=0, countdown=0, total_score=0, high_score=0, banked=0, counters=0.
REQ-036 Reset asserted mid-operation (any state) returns the block to REQ-035 values immediately; high_score is cleared only by reset_n.

Structure
REQ-037 State encodings, LIVES_INIT limits and the sat12 width shall sit in a shared breakout_pkg, also used by the HUD renderer.
REQ-038 One sub-module: ms_tick_gen (prescaler, parameter CLK_FREQ_HZ, output ms_tick).
REQ-039 Target implementation size is 120-400 RTL lines; no multipliers; one 12-bit adder and compare.

Verification (CLK_FREQ_HZ=1000 so ms_tick fires every clk; LOST_MS=4)
REQ-040 Reset, then tap -> next cycle state=1, new_game=1 for one cycle, lives=3, level=1; countdown 3,2,1 for 1000 clks each; state=2 and game_run=1 at clk 3000.
REQ-041 PLAY, score=40, ball_lost=1 -> state=4, lives=2, total_score=40; after 4 clks state=1 with new_game pulse.
REQ-042 PLAY, bricks_alive=0 and ball_lost=1 same cycle -> state=5, level=2, lives unchanged.
REQ-043 Third loss with banked=100, score=20 -> state=6, high_score=120; tap -> state=0; high_score stays 120.
REQ-044 PLAY, pause_tap -> state=3, game_run=0; ball_lost ignored; tap -> state=2.
REQ-045 banked=4090, score=10, ball lost -> total_score=4095; reset_n pulsed in SERVE -> all REQ-035 values.
